snake_frame_reader: RTL and testbench
=====================================

Name: snake_frame_reader

Overview:
Display-side reader of the 34-row x 60-bit snake bitmap RAM that the game-logic writer updates. It sits between the VGA timing generator and the pixel DAC. During horizontal blanking it prefetches the bitmap row for the next scan line through the RAM's second (read) port. It then renders each pixel as snake/dot, background, border or blank, with one registered cycle of latency.

Parameters:
X_MAX, 59, last column index of the playfield (row width = X_MAX+1 bits)
Y_MAX, 33, last row index of the playfield
CELL_SHIFT, 4, log2 of the cell size in pixels (16x16 cells)
H_ACTIVE, 1024, number of visible pixels per line
H_TOTAL, 1344, pixels per line including blanking
V_TOTAL, 806, lines per frame including blanking
RD_LATENCY, 2, clocks from rd_address/rd_en to valid read_data (minimum 1)
SNAKE_COLOR, 12'h0F0, colour of a set cell
BG_COLOR, 12'h000, colour of a clear cell
BORDER_COLOR, 12'h00F, colour of visible pixels outside the playfield

Ports:
clk  in  1  system clock (the pixel clock)
rst  in  1  asynchronous, active-low reset
h_cnt  in  11  horizontal pixel counter from the timing generator, 0..H_TOTAL-1
v_cnt  in  11  vertical line counter, 0..V_TOTAL-1
video_on  in  1  high while (h_cnt, v_cnt) is in the visible area
hsync_in  in  1  horizontal sync from the timing generator
vsync_in  in  1  vertical sync from the timing generator
rd_address  out  6  bitmap RAM read-port row address
rd_en  out  1  read strobe, one cycle per fetch
read_data  in  60  bitmap row returned by the RAM (bit n = column n)
rgb  out  12  pixel colour {R[3:0],G[3:0],B[3:0]}, registered
hsync_out  out  1  hsync_in delayed one cycle, aligned with rgb
vsync_out  out  1  vsync_in delayed one cycle, aligned with rgb
fetch_late  out  1  sticky flag: a line swap happened before its fetch completed

Behaviour:
- Reset values: rgb=0, hsync_out=0, vsync_out=0, rd_en=0, rd_address=0, fetch_late=0, both line buffers=0, FSM=IDLE.
- next_v = (v_cnt==V_TOTAL-1) ? 0 : v_cnt+1; tgt_row = next_v >> CELL_SHIFT.
- FSM states and transitions:
  - IDLE: on h_cnt==H_ACTIVE, if tgt_row<=Y_MAX go to ADDR. Otherwise load next_buf=0, set next_row=tgt_row and go to DONE, with no RAM access.
  - ADDR: rd_address<=tgt_row, rd_en<=1 for exactly one cycle, next_row<=tgt_row. Go to WAIT.
  - WAIT: counts RD_LATENCY-1 cycles; rd_en=0. Go to LATCH.
  - LATCH: next_buf<=read_data. Go to DONE.
  - DONE: hold until the swap, then go to IDLE.
- Swap on h_cnt==H_TOTAL-1: cur_buf<=next_buf, cur_row<=next_row.
  - If the FSM is not in DONE or IDLE at the swap, set fetch_late=1 (cleared only by reset).
  - In that case cur_buf still takes the current next_buf and the fetch is abandoned: FSM returns to IDLE.
- Fetch trigger and swap in the same cycle cannot occur because H_TOTAL-1 > H_ACTIVE; no special handling is required.
- Pixel path, one registered cycle: col = h_cnt >> CELL_SHIFT.
  - !video_on: rgb<=0.
  - video_on, col<=X_MAX and cur_row<=Y_MAX: rgb <= cur_buf[col] ? SNAKE_COLOR : BG_COLOR.
  - video_on, otherwise: rgb<=BORDER_COLOR.
- Column index width is 6 bits. When col>X_MAX, cur_buf must not be indexed out of range; the border branch takes priority.
- Wrap: last line (v_cnt=V_TOTAL-1) prefetches row 0 for line 0.
- Reset mid-fetch: FSM returns to IDLE, buffers clear. The first frame after reset renders background/border until the first valid swap.
- The reader never writes the RAM. Writer updates during scan may produce a one-line tear, which is accepted.

Optional Feature:
GRID_EN
- Defined: pixels inside the playfield whose h_cnt or v_cnt low CELL_SHIFT bits are all zero render as 12'h333. This applies only when the cell is clear; set cells keep SNAKE_COLOR.
- Undefined: no grid; behaviour exactly as above.

Decomposition:
- Package snake_pkg holds:
  - X_MAX, Y_MAX, ROW_W=60, ADDR_W=6
  - colour constants SNAKE_COLOR, BG_COLOR, BORDER_COLOR, GRID_COLOR
  - the fetch FSM state enum {IDLE, ADDR, WAIT, LATCH, DONE}
- The writer block shares X_MAX/Y_MAX/ROW_W from the same package.
- One sub-module: snake_row_fetcher. It contains the FSM, the latency counter, next_buf and the fetch_late logic. The top level keeps the swap, the pixel mux and the sync delay.

Test Plan:
1. Reset release, RAM all zero, one frame -> visible pixels with col<=59 and row<=33 are 12'h000, other visible pixels 12'h00F, blanking 0; fetch_late=0.
2. RAM row 0 = bit 2 set; at v_cnt=0, h_cnt=32..47 -> rgb=12'h0F0 one cycle later, and h_cnt=31 and 48 -> 12'h000.
3. At h_cnt=1024 on v_cnt=15 -> rd_en high exactly one cycle with rd_address=1; read_data sampled RD_LATENCY=2 cycles later lands in cur_buf at line 16.
4. v_cnt=543→544 (row 34 > Y_MAX) -> no rd_en pulse; lines 544+ visible pixels = 12'h00F. On v_cnt=805 -> rd_address=0 fetched for line 0.
5. RD_LATENCY=400 override -> fetch_late rises at first swap and stays 1 until rst=0.
6. GRID_EN defined, all-zero RAM -> h_cnt=16, v_cnt=5 gives 12'h333 and h_cnt=17 gives 12'h000; hsync_out/vsync_out lag inputs by exactly 1 cycle.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared playfield geometry, colours and fetch FSM states for the snake
// bitmap writer and the display-side reader.
package snake_pkg;

    localparam int X_MAX  = 59;
    localparam int Y_MAX  = 33;
    localparam int ROW_W  = X_MAX + 1;
    localparam int ADDR_W = 6;

    localparam logic [11:0] SNAKE_COLOR  = 12'h0F0;
    localparam logic [11:0] BG_COLOR     = 12'h000;
    localparam logic [11:0] BORDER_COLOR = 12'h00F;
    localparam logic [11:0] GRID_COLOR   = 12'h333;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        LATCH,
        DONE
    } fetch_state_t;

endpackage

// File: rtl/snake_row_fetcher.sv
// Prefetches the bitmap row for the next scan line during horizontal blanking
// and flags lines whose fetch was still in flight when the line buffers swapped.
module snake_row_fetcher
    import snake_pkg::*;
#(
    parameter int RD_LATENCY = 2,
    parameter int CELL_SHIFT = 4,
    parameter int H_ACTIVE   = 1024,
    parameter int H_TOTAL    = 1344,
    parameter int V_TOTAL    = 806
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       h_cnt,
    input  logic [10:0]       v_cnt,
    input  logic [ROW_W-1:0]  read_data,
    output logic [ADDR_W-1:0] rd_address,
    output logic              rd_en,
    output logic [ROW_W-1:0]  next_buf,
    output logic [ADDR_W-1:0] next_row,
    output logic              fetch_late
);

    localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [10:0] H_FETCH = 11'(H_ACTIVE);
    localparam logic [10:0] H_SWAP  = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RD_LATENCY - 1);

    fetch_state_t      state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [10:0]       next_v;
    logic [10:0]       tgt_full;
    logic [ADDR_W-1:0] tgt_row;
    logic              tgt_in_range;
    logic              swap;

    // The last line of the frame wraps so row 0 is ready for line 0.
    assign next_v       = (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
    assign tgt_full     = next_v >> CELL_SHIFT;
    assign tgt_row      = tgt_full[ADDR_W-1:0];
    assign tgt_in_range = (tgt_full <= 11'(Y_MAX));
    assign swap         = (h_cnt == H_SWAP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            rd_address <= '0;
            rd_en      <= 1'b0;
            next_buf   <= '0;
            next_row   <= '0;
            fetch_late <= 1'b0;
        end else begin
            rd_en <= 1'b0;
            // A swap always wins; an unfinished fetch is dropped and flagged.
            if (swap) begin
                if (state != IDLE && state != DONE) begin
                    fetch_late <= 1'b1;
                end
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (h_cnt == H_FETCH) begin
                            if (tgt_in_range) begin
                                state <= ADDR;
                            end else begin
                                next_buf <= '0;
                                next_row <= tgt_row;
                                state    <= DONE;
                            end
                        end
                    end
                    ADDR: begin
                        rd_address <= tgt_row;
                        rd_en      <= 1'b1;
                        next_row   <= tgt_row;
                        wait_cnt   <= '0;
                        state      <= WAIT;
                    end
                    WAIT: begin
                        if (wait_cnt == WAIT_LAST) begin
                            state <= LATCH;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    LATCH: begin
                        next_buf <= read_data;
                        state    <= DONE;
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/snake_frame_reader.sv
// Display-side snake bitmap reader: double-buffered row prefetch plus a
// registered pixel mux. Define GRID_EN to draw cell grid lines on clear cells.
module snake_frame_reader
    import snake_pkg::*;
#(
    parameter int RD_LATENCY = 2,
    parameter int CELL_SHIFT = 4,
    parameter int H_ACTIVE   = 1024,
    parameter int H_TOTAL    = 1344,
    parameter int V_TOTAL    = 806
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       h_cnt,
    input  logic [10:0]       v_cnt,
    input  logic              video_on,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic [ADDR_W-1:0] rd_address,
    output logic              rd_en,
    input  logic [ROW_W-1:0]  read_data,
    output logic [11:0]       rgb,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              fetch_late
);

    localparam logic [10:0] H_SWAP = 11'(H_TOTAL - 1);

    logic [ROW_W-1:0]  next_buf;
    logic [ADDR_W-1:0] next_row;
    logic [ROW_W-1:0]  cur_buf;
    logic [ADDR_W-1:0] cur_row;
    logic [10:0]       col_full;
    logic              in_field;
    logic              cell_set;
    logic [11:0]       pixel;

    snake_row_fetcher #(
        .RD_LATENCY (RD_LATENCY),
        .CELL_SHIFT (CELL_SHIFT),
        .H_ACTIVE   (H_ACTIVE),
        .H_TOTAL    (H_TOTAL),
        .V_TOTAL    (V_TOTAL)
    ) u_fetcher (
        .clk        (clk),
        .rst        (rst),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .read_data  (read_data),
        .rd_address (rd_address),
        .rd_en      (rd_en),
        .next_buf   (next_buf),
        .next_row   (next_row),
        .fetch_late (fetch_late)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_buf <= '0;
            cur_row <= '0;
        end else if (h_cnt == H_SWAP) begin
            cur_buf <= next_buf;
            cur_row <= next_row;
        end
    end

    // Border test uses the full column so the buffer is only indexed in range.
    assign col_full = h_cnt >> CELL_SHIFT;
    assign in_field = (col_full <= 11'(X_MAX)) && (cur_row <= ADDR_W'(Y_MAX));
    assign cell_set = in_field ? cur_buf[col_full[ADDR_W-1:0]] : 1'b0;

    always_comb begin
        pixel = BG_COLOR;
        if (!video_on) begin
            pixel = 12'h000;
        end else if (!in_field) begin
            pixel = BORDER_COLOR;
        end else if (cell_set) begin
            pixel = SNAKE_COLOR;
`ifdef GRID_EN
        end else if ((h_cnt[CELL_SHIFT-1:0] == '0) || (v_cnt[CELL_SHIFT-1:0] == '0)) begin
            pixel = GRID_COLOR;
`endif
        end else begin
            pixel = BG_COLOR;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb       <= '0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            rgb       <= pixel;
            hsync_out <= hsync_in;
            vsync_out <= vsync_in;
        end
    end

endmodule

// File: tb/tb_snake_frame_reader.sv
// Bench for snake_frame_reader: drives selected scan lines, models the RAM
// read port and checks every output cycle against a line-level model.
module tb_snake_frame_reader;

    localparam int H_ACT    = 1024;
    localparam int H_TOT    = 1344;
    localparam int V_TOT    = 806;
    localparam int RD_LAT   = 2;
    localparam int SLOW_LAT = 400;
`ifdef GRID_EN
    localparam bit GRID_ON = 1'b1;
`else
    localparam bit GRID_ON = 1'b0;
`endif
    localparam logic [11:0] CLR_GRIDLINE = GRID_ON ? 12'h333 : 12'h000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] h_cnt = '0;
    logic [10:0] v_cnt = '0;
    logic        video_on = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [5:0]  rd_address;
    logic        rd_en;
    logic [59:0] read_data;
    logic [11:0] rgb;
    logic        hsync_out;
    logic        vsync_out;
    logic        fetch_late;

    logic [5:0]  slow_rd_address;
    logic        slow_rd_en;
    logic [59:0] slow_read_data = '0;
    logic [11:0] slow_rgb;
    logic        slow_hsync_out;
    logic        slow_vsync_out;
    logic        slow_fetch_late;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    snake_frame_reader #(.RD_LATENCY(RD_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .video_on   (video_on),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .rd_address (rd_address),
        .rd_en      (rd_en),
        .read_data  (read_data),
        .rgb        (rgb),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .fetch_late (fetch_late)
    );

    snake_frame_reader #(.RD_LATENCY(SLOW_LAT)) dut_slow (
        .clk        (clk),
        .rst        (rst),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .video_on   (video_on),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .rd_address (slow_rd_address),
        .rd_en      (slow_rd_en),
        .read_data  (slow_read_data),
        .rgb        (slow_rgb),
        .hsync_out  (slow_hsync_out),
        .vsync_out  (slow_vsync_out),
        .fetch_late (slow_fetch_late)
    );

    // Bitmap RAM read port: data valid for exactly one cycle, RD_LAT clocks after rd_en.
    logic [59:0] ram [0:33];
    logic [5:0]  pipe_addr [RD_LAT];
    logic        pipe_vld  [RD_LAT];

    function automatic logic [59:0] ram_row(input int r);
        if (r < 0 || r > 33) return '0;
        return ram[r];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_addr[i] <= '0;
            end
        end else begin
            pipe_vld[0]  <= rd_en;
            pipe_addr[0] <= rd_address;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end
        end
    end

    always_comb begin
        read_data = 60'hDEADBEEFCAFEF00;
        if (pipe_vld[RD_LAT-1]) read_data = ram_row(int'(pipe_addr[RD_LAT-1]));
    end

    // Line-level model: a line shows the row read during the previous line's blanking.
    function automatic logic [11:0] pixel_of(input int h, input int v, input logic von,
                                             input int row, input logic [59:0] data);
        int col;
        col = h / 16;
        if (!von) return 12'h000;
        if (col > 59 || row > 33) return 12'h00F;
        if (data[col]) return 12'h0F0;
        if (GRID_ON && (h % 16 == 0 || v % 16 == 0)) return 12'h333;
        return 12'h000;
    endfunction

    function automatic int row_after(input int v);
        return ((v == V_TOT - 1) ? 0 : v + 1) / 16;
    endfunction

    int          m_row;
    logic [59:0] m_data;
    int          p_row;
    logic [59:0] p_data;
    logic [11:0] exp_rgb;
    logic        exp_hs;
    logic        exp_vs;
    int          smp_h;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_row   <= 0;
            m_data  <= '0;
            p_row   <= 0;
            p_data  <= '0;
            exp_rgb <= '0;
            exp_hs  <= 1'b0;
            exp_vs  <= 1'b0;
            smp_h   <= 0;
        end else begin
            exp_rgb <= pixel_of(int'(h_cnt), int'(v_cnt), video_on, m_row, m_data);
            exp_hs  <= hsync_in;
            exp_vs  <= vsync_in;
            smp_h   <= int'(h_cnt);
            if (int'(h_cnt) == H_ACT) begin
                p_row  <= row_after(int'(v_cnt));
                p_data <= ram_row(row_after(int'(v_cnt)));
            end
            if (int'(h_cnt) == H_TOT - 1) begin
                m_row  <= p_row;
                m_data <= p_data;
            end
        end
    end

    task automatic check_value(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    bit          chk_on = 1'b0;
    logic [11:0] line_rgb [0:H_TOT-1];
    int          rd_pulses = 0;
    logic [5:0]  rd_last = '0;

    always @(negedge clk) begin
        if (chk_on) begin
            check_value("rgb", 64'(rgb), 64'(exp_rgb));
            check_value("hsync_out", 64'(hsync_out), 64'(exp_hs));
            check_value("vsync_out", 64'(vsync_out), 64'(exp_vs));
            check_value("fetch_late", 64'(fetch_late), 64'd0);
            line_rgb[smp_h] <= rgb;
            if (smp_h == 0) rd_pulses = 0;
            if (rd_en) begin
                rd_pulses++;
                rd_last = rd_address;
            end
        end
    end

    task automatic run_line(input int v);
        for (int h = 0; h < H_TOT; h++) begin
            @(posedge clk);
            #2;
            h_cnt    = 11'(h);
            v_cnt    = 11'(v);
            video_on = (h < H_ACT) && (v < 768);
            hsync_in = !(h >= 1048 && h < 1184);
            vsync_in = !(v >= 771 && v < 777);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_rgb"}, 64'(rgb), 64'd0);
        check_value({tag, "_hsync"}, 64'(hsync_out), 64'd0);
        check_value({tag, "_vsync"}, 64'(vsync_out), 64'd0);
        check_value({tag, "_rd_en"}, 64'(rd_en), 64'd0);
        check_value({tag, "_rd_addr"}, 64'(rd_address), 64'd0);
        check_value({tag, "_late"}, 64'(fetch_late), 64'd0);
        check_value({tag, "_slow_late"}, 64'(slow_fetch_late), 64'd0);
    endtask

    initial begin
        for (int r = 0; r <= 33; r++) ram[r] = '0;

        check_value("pin_model_snake", 64'(pixel_of(40, 1, 1'b1, 0, 60'h4)), 64'h0F0);
        check_value("pin_model_border", 64'(pixel_of(960, 1, 1'b1, 0, 60'h0)), 64'h00F);
        check_value("pin_model_row34", 64'(pixel_of(33, 1, 1'b1, 34, 60'hF)), 64'h00F);
        check_value("pin_model_blank", 64'(pixel_of(1100, 1, 1'b0, 0, 60'hF)), 64'h000);
        check_value("pin_model_wrap", 64'(row_after(805)), 64'd0);

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #2;
        rst    = 1'b1;
        chk_on = 1'b1;

        // All-zero RAM: field background, border past column 59, blanking black.
        run_line(805);
        check_value("wrap_rd_pulses", 64'(rd_pulses), 64'd1);
        check_value("wrap_rd_addr", 64'(rd_last), 64'd0);
        check_value("slow_late_before_swap", 64'(slow_fetch_late), 64'd0);
        run_line(0);
        check_value("l0_h0", 64'(line_rgb[0]), 64'(CLR_GRIDLINE));
        check_value("l0_h959", 64'(line_rgb[959]), 64'(CLR_GRIDLINE));
        check_value("l0_h960", 64'(line_rgb[960]), 64'h00F);
        check_value("l0_h1023", 64'(line_rgb[1023]), 64'h00F);
        check_value("l0_h1100", 64'(line_rgb[1100]), 64'h000);
        check_value("slow_late_after_swap", 64'(slow_fetch_late), 64'd1);

        // Column 2 of row 0 set: pixels 32..47 of line 0.
        ram[0] = 60'h4;
        run_line(805);
        run_line(0);
        check_value("c2_h31", 64'(line_rgb[31]), 64'(CLR_GRIDLINE));
        check_value("c2_h32", 64'(line_rgb[32]), 64'h0F0);
        check_value("c2_h47", 64'(line_rgb[47]), 64'h0F0);
        check_value("c2_h48", 64'(line_rgb[48]), 64'(CLR_GRIDLINE));

        // Row 1 fetched on line 15, shown on line 16; edge columns 0 and 59.
        ram[1] = (60'h1 << 59) | 60'h1;
        run_line(15);
        check_value("l15_rd_pulses", 64'(rd_pulses), 64'd1);
        check_value("l15_rd_addr", 64'(rd_last), 64'd1);
        run_line(16);
        check_value("l16_h0", 64'(line_rgb[0]), 64'h0F0);
        check_value("l16_h15", 64'(line_rgb[15]), 64'h0F0);
        check_value("l16_h16", 64'(line_rgb[16]), 64'(CLR_GRIDLINE));
        check_value("l16_h944", 64'(line_rgb[944]), 64'h0F0);
        check_value("l16_h959", 64'(line_rgb[959]), 64'h0F0);
        check_value("l16_h960", 64'(line_rgb[960]), 64'h00F);

        // Row 34 is outside the playfield: no RAM access, whole line border.
        run_line(543);
        check_value("l543_rd_pulses", 64'(rd_pulses), 64'd0);
        run_line(544);
        check_value("l544_h0", 64'(line_rgb[0]), 64'h00F);
        check_value("l544_h959", 64'(line_rgb[959]), 64'h00F);
        run_line(771);
        check_value("l771_rd_pulses", 64'(rd_pulses), 64'd0);
        run_line(805);
        check_value("wrap2_rd_pulses", 64'(rd_pulses), 64'd1);
        check_value("wrap2_rd_addr", 64'(rd_last), 64'd0);
        run_line(0);
        check_value("wrap2_h32", 64'(line_rgb[32]), 64'h0F0);

        // Line 5: grid lines only on columns whose low pixel bits are zero.
        run_line(4);
        run_line(5);
        check_value("l5_h16", 64'(line_rgb[16]), GRID_ON ? 64'h333 : 64'h000);
        check_value("l5_h17", 64'(line_rgb[17]), 64'h000);
        check_value("l5_h32", 64'(line_rgb[32]), 64'h0F0);
        check_value("slow_late_sticky", 64'(slow_fetch_late), 64'd1);

        @(posedge clk);
        #2;
        chk_on = 1'b0;
        rst    = 1'b0;
        #1;
        check_reset_outputs("rereset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
